// File: rtl/uart_rx_apb_ctrl_if.sv
// APB slave bus bundle for uart_rx_apb_ctrl.
//   psel/penable/pwrite/paddr/pwdata : requester -> controller
//   prdata/pready/pslverr            : controller -> requester
interface uart_rx_apb_ctrl_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/uart_rx_apb_ctrl.sv
// APB controller for the UART receive path.
// Buffers received bytes in a FIFO and exposes them through APB registers:
//   0x0 RXDATA (RO, read pops), 0x4 STATUS (RO), 0x8 CTRL (RW), 0xC CLEAR (WO).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : APB slave (zero wait states)
//   rx_data    : received byte, qualified by the rx_valid strobe
//   irq        : level interrupt, irq_en & (not_empty | overrun)
module uart_rx_apb_ctrl #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   uart_rx_apb_ctrl_if.slave       bus,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    irq
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overrun_q;
   logic             rx_en_q, irq_en_q;

   logic       access, rd, wr;
   logic [1:0] addr;
   logic       not_empty, full;
   logic       pop, push, flush, clr_ovr, ovr_set, rx_ok;
   logic [31:0] status;
   logic       unused_bits;

   assign access    = bus.psel & bus.penable;
   assign rd        = access & ~bus.pwrite;
   assign wr        = access & bus.pwrite;
   assign addr      = bus.paddr[3:2];
   assign not_empty = (count_q != '0);
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));

   assign pop     = rd & (addr == 2'd0) & not_empty;
   assign flush   = wr & (addr == 2'd3) & bus.pwdata[1];
   assign clr_ovr = wr & (addr == 2'd3) & bus.pwdata[0];
   assign rx_ok   = rx_valid & rx_en_q;
   // A pop in the same cycle frees the slot a full FIFO needs; a flush drops
   // the incoming byte silently.
   assign push    = rx_ok & (~full | pop) & ~flush;
   assign ovr_set = rx_ok & full & ~pop & ~flush;

   assign bus.pready  = 1'b1;
   assign bus.pslverr = wr & (addr[1] == 1'b0);
   assign irq         = irq_en_q & (not_empty | overrun_q);

   always_comb begin
      status = '0;
      status[0] = not_empty;
      status[1] = full;
      status[2] = overrun_q;
      status[8 +: CNT_W] = count_q;
   end

   always_comb begin
      bus.prdata = '0;
      if (rd) begin
         case (addr)
            2'd0:    bus.prdata = not_empty ? {24'd0, mem[rd_ptr_q]} : 32'd0;
            2'd1:    bus.prdata = status;
            2'd2:    bus.prdata = {30'd0, irq_en_q, rx_en_q};
            default: bus.prdata = '0;
         endcase
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         rx_en_q   <= 1'b0;
         irq_en_q  <= 1'b0;
      end else begin
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
         // Set has priority over a simultaneous clear.
         if (ovr_set)      overrun_q <= 1'b1;
         else if (clr_ovr) overrun_q <= 1'b0;
         if (wr && addr == 2'd2) begin
            rx_en_q  <= bus.pwdata[0];
            irq_en_q <= bus.pwdata[1];
         end
      end
   end

   assign unused_bits = ^{bus.pwdata[31:2], bus.paddr[1:0]};

endmodule
